// File: rtl/switch_debounce_sync.sv
// switch_debounce_sync: two-flop synchroniser plus per-bit stability debouncer with change pulses
module switch_debounce_sync #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1, sync2, chg_nxt;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  // a bit is accepted once it has disagreed with sw_out for DEBOUNCE_CYCLES cycles; any agreement restarts the count
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      chg_nxt[k] = (sync2[k] != sw_out[k]) && (cnt[k] == LAST);
      cnt_nxt[k] = (sync2[k] == sw_out[k] || chg_nxt[k]) ? '0 : cnt[k] + 1'b1;
    end
  end
  // synchroniser chain and debounce state; all outputs come straight from these flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= '0;
      sync2      <= '0;
      sw_out     <= '0;
      sw_changed <= '0;
      any_change <= 1'b0;
      for (int k = 0; k < WIDTH; k++) cnt[k] <= '0;
    end else begin
      sync1      <= sw_in;
      sync2      <= sync1;
      sw_out     <= sw_out ^ chg_nxt;
      sw_changed <= chg_nxt;
      any_change <= |chg_nxt;
      for (int k = 0; k < WIDTH; k++) cnt[k] <= cnt_nxt[k];
    end
  end
endmodule

// File: tb/tb_switch_debounce_sync.sv
// tb_switch_debounce_sync: directed checks of synchronisation latency, debounce filtering and change pulses
module tb_switch_debounce_sync;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sw_in = 8'h00;
  logic [7:0] sw_out, sw_changed;
  logic       any_change;
  int checks = 0;
  int failures = 0;

  switch_debounce_sync #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .sw_in(sw_in),
    .sw_out(sw_out), .sw_changed(sw_changed), .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] o, input logic [7:0] c, input logic a);
    chk({tag, " sw_out"}, sw_out, o);
    chk({tag, " sw_changed"}, sw_changed, c);
    chk({tag, " any_change"}, {7'b0, any_change}, {7'b0, a});
  endtask

  // sw_in already holds tgt; edge 1 is the next posedge; new level expected on edge 6 (D+2)
  task automatic run_step(input string tag, input logic [7:0] base, input logic [7:0] tgt, input int n);
    for (int e = 1; e <= n; e++) begin
      tick();
      chk_all($sformatf("%s e%0d", tag, e), (e >= 6) ? tgt : base,
              (e == 6) ? (base ^ tgt) : 8'h00, (e == 6) && (base != tgt));
    end
  endtask

  initial begin
    logic [4:0] bounce;
    bounce = 5'b10101;
    // 1: switches on through reset, then release
    sw_in = 8'hFF;
    tick();
    tick();
    chk_all("t1 in_reset", 8'h00, 8'h00, 1'b0);
    reset_n = 1'b1;
    run_step("t1 release", 8'h00, 8'hFF, 7);
    sw_in = 8'h00;
    run_step("t1 off", 8'hFF, 8'h00, 7);
    // 2: clean step on bit 0
    sw_in = 8'h01;
    run_step("t2 rise", 8'h00, 8'h01, 7);
    sw_in = 8'h00;
    run_step("t2 fall", 8'h01, 8'h00, 7);
    // 3: three-cycle glitch on bit 3 must be filtered
    sw_in = 8'h08;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk_all($sformatf("t3 hi e%0d", e), 8'h00, 8'h00, 1'b0);
    end
    sw_in = 8'h00;
    for (int e = 4; e <= 11; e++) begin
      tick();
      chk_all($sformatf("t3 lo e%0d", e), 8'h00, 8'h00, 1'b0);
    end
    // 4: bounce 1,0,1,0,1 on bit 5; last rise sampled at edge 5, accepted at edge 10
    for (int e = 1; e <= 12; e++) begin
      sw_in = (e > 5 || bounce[e-1]) ? 8'h20 : 8'h00;
      tick();
      chk_all($sformatf("t4 e%0d", e), (e >= 10) ? 8'h20 : 8'h00,
              (e == 10) ? 8'h20 : 8'h00, e == 10);
    end
    sw_in = 8'h00;
    run_step("t4 fall", 8'h20, 8'h00, 7);
    // 5: simultaneous rise on bits 1 and 7
    sw_in = 8'h82;
    run_step("t5", 8'h00, 8'h82, 7);
    // 6: add bit 2, reset asynchronously when cnt[2]=2, then requalify from zero
    sw_in = 8'h86;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk_all($sformatf("t6 pre e%0d", e), 8'h82, 8'h00, 1'b0);
    end
    reset_n = 1'b0;
    #2;
    chk_all("t6 async_clear", 8'h00, 8'h00, 1'b0);
    #1;
    reset_n = 1'b1;
    run_step("t6 release", 8'h00, 8'h86, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
